// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and ID width helper.
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT
  } arb_state_e;

  // Source tag width; never below one bit so ports stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after rr_last, ascending with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_last,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    // rr_last itself is visited last (k == NUM_REQ), giving it lowest priority.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_last) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Grant is held until packet end or MAX_BURST beats; beats are tagged with the source ID.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ    = 4,
  parameter int unsigned  DATA_WIDTH = 8,
  parameter int unsigned  MAX_BURST  = 8,
  localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_wr_data,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  rr_last_q, rr_last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    pick_req;
  logic [ID_W-1:0]       winner;
  logic                  any_req;
  logic                  granted;
  logic                  pkt_done;
  logic                  burst_done;
  logic                  release_grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (pick_req),
    .rr_last (rr_last_q),
    .any     (any_req),
    .winner  (winner)
  );

  // Write port muxing; nothing is accepted while rst is asserted.
  always_comb begin
    granted      = (state_q == StGrant) && !rst;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (granted) begin
      req_ready[grant_id_q] = !fifo_full;
      fifo_wr_en            = req_valid[grant_id_q] && !fifo_full;
    end
    if (fifo_wr_en) fifo_wr_data = {grant_id_q, data_arr[grant_id_q]};
  end

  always_comb begin
    pkt_done      = fifo_wr_en && req_last[grant_id_q];
    burst_done    = fifo_wr_en && ((beat_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST));
    release_grant = pkt_done || burst_done;
    // A producer whose packet just ended has no pending beat on its valid line; a producer
    // split by MAX_BURST still does and competes at lowest priority.
    pick_req = req_valid;
    if ((state_q == StGrant) && pkt_done) pick_req[grant_id_q] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d    = StGrant;
          grant_id_d = winner;
          rr_last_d  = winner;
          beat_cnt_d = '0;
        end
      end
      StGrant: begin
        if (release_grant) begin
          beat_cnt_d = '0;
          if (any_req) begin
            grant_id_d = winner;
            rr_last_d  = winner;
          end else begin
            state_d = StIdle;
          end
        end else if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_id_q <= '0;
      rr_last_q  <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_valid = (state_q == StGrant);
  assign grant_id    = grant_id_q;

endmodule
